// File: rtl/param_line_rotator.sv
// rtl/param_line_rotator.sv - BT.656 active-line rotator with ping-pong line banks and 2-cycle latency.
// Optional inverse rotation on decrypt is built only when PARAM_LINE_ROTATOR_DECRYPT_EN is defined.
module param_line_rotator #(
    parameter int DATA_WIDTH = 10,
    parameter int ACTIVE_LEN = 1440,
    parameter int CUT_WIDTH  = 8,
    parameter int CUT_SHIFT  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [CUT_WIDTH-1:0]  raw_cut_position,
    input  logic                  H,
    input  logic                  V,
    input  logic                  enable,
    input  logic                  decrypt,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid
);

    localparam int RW = (ACTIVE_LEN > 1) ? $clog2(ACTIVE_LEN) : 1;
    localparam int WW = $clog2(ACTIVE_LEN + 1);
    localparam int SW = CUT_WIDTH + CUT_SHIFT;
    localparam logic [RW-1:0] LAST_ADDR = RW'(ACTIVE_LEN - 1);
    localparam logic [WW-1:0] FULL_CNT  = WW'(ACTIVE_LEN);

    logic [DATA_WIDTH-1:0] bank0_mem [ACTIVE_LEN];
    logic [DATA_WIDTH-1:0] bank1_mem [ACTIVE_LEN];

    logic                  prev_h_q, prev_h_d;
    logic                  armed_q, armed_d;
    logic                  bank_sel_q, bank_sel_d;
    logic [1:0]            full_q, full_d;
    logic [WW-1:0]         wr_idx_q, wr_idx_d;
    logic [RW-1:0]         rd_addr_q, rd_addr_d;
    logic [RW-1:0]         offset_q, offset_d;
    logic [DATA_WIDTH-1:0] din1_q, din1_d;
    logic                  sel1_q, sel1_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dvalid_q, dvalid_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic                  active, line_start, line_end, wr_en;
    logic [SW-1:0]         cut_shifted;
    logic [RW-1:0]         off_new, rd_start, rd_cur, wr_addr;

`ifdef PARAM_LINE_ROTATOR_DECRYPT_EN
    logic decrypt_q, decrypt_d;
`else
    logic unused_decrypt;
    assign unused_decrypt = decrypt;
`endif

    always_comb begin
        active     = !H && !V;
        // armed_q blocks the tail of a line interrupted by reset from being mistaken for a new line
        line_start = armed_q && prev_h_q && active;
        line_end   = H && !prev_h_q;

        cut_shifted = SW'(raw_cut_position) << CUT_SHIFT;
        if (!enable)
            off_new = '0;
        else if (32'(cut_shifted) > 32'(ACTIVE_LEN - 1))
            off_new = LAST_ADDR;
        else
            off_new = RW'(cut_shifted);
        offset_d = line_start ? off_new : offset_q;

`ifdef PARAM_LINE_ROTATOR_DECRYPT_EN
        decrypt_d = line_start ? decrypt : decrypt_q;
        rd_start  = (decrypt_d && offset_d != '0) ? RW'(ACTIVE_LEN - int'(offset_d)) : offset_d;
`else
        rd_start  = offset_d;
`endif

        rd_cur    = line_start ? rd_start : rd_addr_q;
        rd_addr_d = rd_addr_q;
        if (active)
            rd_addr_d = (rd_cur == LAST_ADDR) ? '0 : rd_cur + RW'(1);

        wr_en      = armed_q && active && (wr_idx_q != FULL_CNT);
        wr_addr    = wr_idx_q[RW-1:0];
        wr_idx_d   = wr_idx_q;
        bank_sel_d = bank_sel_q;
        full_d     = full_q;
        if (line_end) begin
            if (wr_idx_q != '0) begin
                wr_idx_d           = '0;
                bank_sel_d         = !bank_sel_q;
                full_d[bank_sel_q] = 1'b1;
            end
        end else if (wr_en) begin
            wr_idx_d = wr_idx_q + WW'(1);
        end

        prev_h_d = H;
        armed_d  = armed_q || H;

        din1_d   = data_in;
        sel1_d   = active && full_q[!bank_sel_q];
        dout_d   = sel1_q ? rd_data_q : din1_q;
        dvalid_d = sel1_q;
    end

    // Write bank is bank_sel_q, read bank the other; swaps only happen in blanking.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            if (bank_sel_q)
                bank1_mem[wr_addr] <= data_in;
            else
                bank0_mem[wr_addr] <= data_in;
        end
        rd_data_q <= bank_sel_q ? bank0_mem[rd_cur] : bank1_mem[rd_cur];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_h_q   <= 1'b1;
            armed_q    <= 1'b0;
            bank_sel_q <= 1'b0;
            full_q     <= '0;
            wr_idx_q   <= '0;
            rd_addr_q  <= '0;
            offset_q   <= '0;
            din1_q     <= '0;
            sel1_q     <= 1'b0;
            dout_q     <= '0;
            dvalid_q   <= 1'b0;
`ifdef PARAM_LINE_ROTATOR_DECRYPT_EN
            decrypt_q  <= 1'b0;
`endif
        end else begin
            prev_h_q   <= prev_h_d;
            armed_q    <= armed_d;
            bank_sel_q <= bank_sel_d;
            full_q     <= full_d;
            wr_idx_q   <= wr_idx_d;
            rd_addr_q  <= rd_addr_d;
            offset_q   <= offset_d;
            din1_q     <= din1_d;
            sel1_q     <= sel1_d;
            dout_q     <= dout_d;
            dvalid_q   <= dvalid_d;
`ifdef PARAM_LINE_ROTATOR_DECRYPT_EN
            decrypt_q  <= decrypt_d;
`endif
        end
    end

    assign data_out   = dout_q;
    assign data_valid = dvalid_q;

endmodule
